div_unit: RTL and testbench

//  Iterative RV32M divider (DIV/DIVU/REM/REMU) in the execute stage. Consumes rs1_d/rs2_d read

---
 rtl/div_unit.sv | 191 +++++++++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative RV32M divider: restoring radix-2, one quotient bit per cycle.
// Handles DIV/DIVU/REM/REMU including the divide-by-zero and signed-overflow
// cases, which complete in a single cycle without entering the iteration.
module div_unit #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [XLEN-1:0]     rs1_d,
  input  logic [XLEN-1:0]     rs2_d,
  input  logic [ADDR_LEN-1:0] rd_in,
  output logic                busy,
  output logic                done,
  output logic [ADDR_LEN-1:0] rd,
  output logic [XLEN-1:0]     rd_d,
  output logic                reg_wr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ZERO_C    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_C    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN_C = {1'b1, {(XLEN-1){1'b0}}};

  state_t                state_r, state_next_s;
  logic [4:0]            count_r;
  logic [1:0]            op_r;
  logic [XLEN-1:0]       quo_r;      // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]       rem_r;      // partial remainder, always < divisor magnitude
  logic [XLEN-1:0]       div_r;      // divisor magnitude
  logic                  neg_q_r;
  logic                  neg_r_r;
  logic [ADDR_LEN-1:0]   rd_r;
  logic [XLEN-1:0]       rd_d_r;
  logic                  busy_r, done_r, reg_wr_r;

  logic                  signed_op_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]       a_mag_s, b_mag_s;
  logic                  special_s;
  logic [XLEN-1:0]       special_res_s;
  logic [XLEN:0]         rem_shift_s, diff_s;
  logic                  ge_s;
  logic [XLEN-1:0]       rem_step_s, quo_step_s;
  logic [XLEN-1:0]       q_fix_s, r_fix_s;
  logic                  accept_s;
  logic [ADDR_LEN-1:0]   rd_next_s;

  // Operand decode: sign handling, magnitudes and the single-cycle special cases
  always_comb begin
    signed_op_s   = ~op[0];
    a_neg_s       = signed_op_s & rs1_d[XLEN-1];
    b_neg_s       = signed_op_s & rs2_d[XLEN-1];
    a_mag_s       = a_neg_s ? (ZERO_C - rs1_d) : rs1_d;
    b_mag_s       = b_neg_s ? (ZERO_C - rs2_d) : rs2_d;
    special_s     = 1'b0;
    special_res_s = ZERO_C;
    if (rs2_d == ZERO_C) begin
      special_s     = 1'b1;
      special_res_s = op[1] ? rs1_d : ONES_C;
    end else if (signed_op_s && (rs1_d == INT_MIN_C) && (rs2_d == ONES_C)) begin
      special_s     = 1'b1;
      special_res_s = op[1] ? ZERO_C : INT_MIN_C;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_C;
    end
  end

  // One restoring step plus the final sign fix-up of quotient and remainder
  always_comb begin
    rem_shift_s = {rem_r, quo_r[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, div_r};
    ge_s        = ~diff_s[XLEN];
    rem_step_s  = ge_s ? diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
    quo_step_s  = {quo_r[XLEN-2:0], ge_s};
    q_fix_s     = neg_q_r ? (ZERO_C - quo_r) : quo_r;
    r_fix_s     = neg_r_r ? (ZERO_C - rem_r) : rem_r;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    rd_next_s    = rd_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          rd_next_s    = rd_in;
          state_next_s = special_s ? S_DONE : S_CALC;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (count_r == 5'd31) begin
          state_next_s = S_FIX;
        end else begin
          state_next_s = S_CALC;
        end
      end
      S_FIX:   state_next_s = S_DONE;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, select result in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 5'd0;
      op_r    <= 2'd0;
      quo_r   <= ZERO_C;
      rem_r   <= ZERO_C;
      div_r   <= ZERO_C;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      rd_r    <= {ADDR_LEN{1'b0}};
      rd_d_r  <= ZERO_C;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            count_r <= 5'd0;
            op_r    <= op;
            quo_r   <= a_mag_s;
            rem_r   <= ZERO_C;
            div_r   <= b_mag_s;
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            rd_r    <= rd_in;
            if (special_s) begin
              rd_d_r <= special_res_s;
            end
          end
        end
        S_CALC: begin
          rem_r   <= rem_step_s;
          quo_r   <= quo_step_s;
          count_r <= count_r + 5'd1;
        end
        S_FIX: begin
          rd_d_r <= op_r[1] ? r_fix_s : q_fix_s;
        end
        S_DONE: begin
          rd_d_r <= rd_d_r;
        end
        default: begin
          count_r <= 5'd0;
        end
      endcase
    end
  end

  // Registered status outputs, derived from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      reg_wr_r <= 1'b0;
    end else begin
      busy_r   <= (state_next_s != S_IDLE);
      done_r   <= (state_next_s == S_DONE);
      reg_wr_r <= (state_next_s == S_DONE) && (rd_next_s != {ADDR_LEN{1'b0}});
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign reg_wr = reg_wr_r;
  assign rd     = rd_r;
  assign rd_d   = rd_d_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, hand-written
// multi-cycle sequences and randomized operations against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_d, rs2_d;
  logic [4:0]  rd_in;
  logic        busy, done, reg_wr;
  logic [4:0]  rd;
  logic [31:0] rd_d;

  int pass_cnt = 0;
  int total_cnt = 0;

  div_unit #(.XLEN(32), .ADDR_LEN(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_in(rd_in), .busy(busy), .done(done), .rd(rd), .rd_d(rd_d), .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference: RISC-V division semantics written with plain SV arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op in cycle 0 and check result, latency, rd, reg_wr and hold behaviour
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp, input int exp_lat, input string nm);
    int cyc;
    bit seen;
    @(negedge clk);
    op = o; rs1_d = a; rs2_d = b; rd_in = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({nm, " busy_c1"}, {31'd0, busy}, 32'd1);
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({nm, " done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({nm, " latency"}, cyc, exp_lat);
      chk({nm, " rd_d"}, rd_d, exp);
      chk({nm, " rd"}, {27'd0, rd}, {27'd0, r});
      chk({nm, " reg_wr"}, {31'd0, reg_wr}, {31'd0, (r != 5'd0)});
      @(negedge clk);
      chk({nm, " done_clear"}, {31'd0, done}, 32'd0);
      chk({nm, " busy_clear"}, {31'd0, busy}, 32'd0);
      chk({nm, " rd_d_hold"}, rd_d, exp);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int first_done, second_done, n_done;
    logic [31:0] first_val, second_val;
    logic [4:0]  first_rd, second_rd;
    bit          bad_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rr;

    vecs.push_back('{2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 34});
    vecs.push_back('{2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 34});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 34});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 34});
    vecs.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 34});
    vecs.push_back('{2'b01, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1});
    vecs.push_back('{2'b11, 32'd5, 32'd0, 5'd6, 32'd5, 1});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 1});
    vecs.push_back('{2'b00, 32'd5, 32'd0, 5'd0, 32'hFFFF_FFFF, 1});
    vecs.push_back('{2'b01, 32'd9, 32'd3, 5'd0, 32'd3, 34});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 34});
    vecs.push_back('{2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd2, 32'd14, 34});

    rst = 1'b1; start = 1'b0; op = 2'b00; rs1_d = 32'd0; rs2_d = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("reset rd", {27'd0, rd}, 32'd0);
    chk("reset rd_d", rd_d, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
                             $sformatf("vec%0d", i));

    // start held high through the first op: second op accepted at first IDLE cycle
    n_done = 0; first_done = -1; second_done = -1;
    first_val = 32'd0; second_val = 32'd0; first_rd = 5'd0; second_rd = 5'd0;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin first_done = c; first_val = rd_d; first_rd = rd; end
        else if (n_done == 2) begin second_done = c; second_val = rd_d; second_rd = rd; end
      end
      start = (c <= 40);
      if (c == 0) begin op = 2'b01; rs1_d = 32'd100; rs2_d = 32'd7; rd_in = 5'd5; end
      else begin op = 2'b01; rs1_d = 32'd1000; rs2_d = 32'd3; rd_in = 5'd9; end
    end
    start = 1'b0;
    chk("b2b first cycle", first_done, 34);
    chk("b2b first rd_d", first_val, 32'd14);
    chk("b2b first rd", {27'd0, first_rd}, 32'd5);
    chk("b2b second cycle", second_done, 69);
    chk("b2b second rd_d", second_val, 32'd333);
    chk("b2b second rd", {27'd0, second_rd}, 32'd9);
    chk("b2b done count", n_done, 2);

    // Reset in cycle 10 aborts the op
    bad_done = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      if (c >= 1 && (done || reg_wr)) bad_done = 1'b1;
      if (c == 11) begin
        chk("abort busy c11", {31'd0, busy}, 32'd0);
        chk("abort rd_d c11", rd_d, 32'd0);
      end
      start = (c == 0);
      rst = (c == 10);
      op = 2'b01; rs1_d = 32'd100; rs2_d = 32'd7; rd_in = 5'd5;
    end
    chk("abort no done", {31'd0, bad_done}, 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      rr = 5'($urandom_range(0, 31));
      run_op(ro, ra, rb, rr, ref_res(ro, ra, rb), ref_lat(ro, ra, rb), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
